// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: shares one system bus between the core load/store path and the
// GEMM accelerator's memory master.
//
// Arbitration is round-robin with a grant lock: once a request is on the bus and stalled
// (bus_ready low), the grant stays with that requester until it is accepted. Accepted reads
// record their requester in an ID FIFO so the in-order read responses can be steered back.
//
// Build option:
//   SYS_BUS_ARB_CORE_PRIO_EN  when defined, the core wins every tie (fixed priority);
//                             otherwise ties alternate (round-robin).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   core_* / gemm_*          requester side: en/rdwr/addr/wr_data/mask in, ready/rd_valid out
//   rd_data                  shared read data (pass-through of bus_rd_data)
//   bus_en .. bus_mask       downstream request, muxed from the granted requester
//   bus_ready                downstream accepts the current request
//   bus_rd_valid/_rd_data    in-order read response from downstream
//   outstanding              number of reads in flight
//   err_unexp                sticky flag: a response arrived with no read in flight
module sys_bus_arbiter #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned OUTST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_en,
  input  logic                       core_rdwr,
  input  logic [AW-1:0]              core_addr,
  input  logic [DW-1:0]              core_wr_data,
  input  logic [DW/8-1:0]            core_mask,
  output logic                       core_ready,
  output logic                       core_rd_valid,
  input  logic                       gemm_en,
  input  logic                       gemm_rdwr,
  input  logic [AW-1:0]              gemm_addr,
  input  logic [DW-1:0]              gemm_wr_data,
  input  logic [DW/8-1:0]            gemm_mask,
  output logic                       gemm_ready,
  output logic                       gemm_rd_valid,
  output logic [DW-1:0]              rd_data,
  output logic                       bus_en,
  output logic                       bus_rdwr,
  output logic [AW-1:0]              bus_addr,
  output logic [DW-1:0]              bus_wr_data,
  output logic [DW/8-1:0]            bus_mask,
  input  logic                       bus_ready,
  input  logic                       bus_rd_valid,
  input  logic [DW-1:0]              bus_rd_data,
  output logic [$clog2(OUTST):0]     outstanding,
  output logic                       err_unexp
);

  localparam int unsigned PW = $clog2(OUTST);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IdCore = 1'b0, IdGemm = 1'b1} req_id_e;

  // Arbitration state
  logic    lock_valid_q, lock_valid_d;
  req_id_e lock_id_q, lock_id_d;
`ifndef SYS_BUS_ARB_CORE_PRIO_EN
  req_id_e last_grant_q, last_grant_d;
`endif

  // Read ID FIFO state
  logic [OUTST-1:0] id_q, id_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic    not_full, fifo_empty;
  logic    core_elig, gemm_elig;
  logic    grant_valid;
  req_id_e grant_id;
  req_id_e head_id;
  logic    accept, push, pop;

  // Reads are blocked on a full FIFO even if a response pops in the same cycle.
  assign not_full   = (count_q < CW'(OUTST));
  assign fifo_empty = (count_q == '0);
  assign core_elig  = core_en & (core_rdwr | not_full);
  assign gemm_elig  = gemm_en & (gemm_rdwr | not_full);
  assign head_id    = req_id_e'(id_q[rd_ptr_q]);

  // Grant selection
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = IdCore;
    if (lock_valid_q) begin
      // A locked requester that drops en gets no grant; the lock clears at the next edge.
      grant_id    = lock_id_q;
      grant_valid = (lock_id_q == IdCore) ? core_en : gemm_en;
    end else if (core_elig && gemm_elig) begin
      grant_valid = 1'b1;
`ifdef SYS_BUS_ARB_CORE_PRIO_EN
      grant_id    = IdCore;
`else
      grant_id    = (last_grant_q == IdCore) ? IdGemm : IdCore;
`endif
    end else if (core_elig) begin
      grant_valid = 1'b1;
      grant_id    = IdCore;
    end else if (gemm_elig) begin
      grant_valid = 1'b1;
      grant_id    = IdGemm;
    end
  end

  // Outputs
  always_comb begin
    bus_en      = grant_valid;
    bus_rdwr    = 1'b0;
    bus_addr    = '0;
    bus_wr_data = '0;
    bus_mask    = '0;
    if (grant_valid) begin
      if (grant_id == IdCore) begin
        bus_rdwr    = core_rdwr;
        bus_addr    = core_addr;
        bus_wr_data = core_wr_data;
        bus_mask    = core_mask;
      end else begin
        bus_rdwr    = gemm_rdwr;
        bus_addr    = gemm_addr;
        bus_wr_data = gemm_wr_data;
        bus_mask    = gemm_mask;
      end
    end
    core_ready    = grant_valid & (grant_id == IdCore) & bus_ready;
    gemm_ready    = grant_valid & (grant_id == IdGemm) & bus_ready;
    core_rd_valid = pop & (head_id == IdCore);
    gemm_rd_valid = pop & (head_id == IdGemm);
    rd_data       = bus_rd_data;
    outstanding   = count_q;
    err_unexp     = err_q;
  end

  assign accept = grant_valid & bus_ready;
  assign push   = accept & ~bus_rdwr;
  // A response with nothing in flight is flagged instead of popping.
  assign pop    = bus_rd_valid & ~fifo_empty;

  // Next state
  always_comb begin
    lock_valid_d = grant_valid & ~bus_ready;
    lock_id_d    = grant_id;
`ifndef SYS_BUS_ARB_CORE_PRIO_EN
    last_grant_d = accept ? grant_id : last_grant_q;
`endif
    id_d     = id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      id_d[wr_ptr_q] = grant_id;
      wr_ptr_d       = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_d = err_q | (bus_rd_valid & fifo_empty);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= IdCore;
`ifndef SYS_BUS_ARB_CORE_PRIO_EN
      last_grant_q <= IdGemm;  // core wins the first tie
`endif
      id_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
`ifndef SYS_BUS_ARB_CORE_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
      id_q         <= id_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

endmodule
